// File: rtl/mc_arb_pkg.sv
// Shared types and field layout for the memory-controller port arbiter.
package mc_arb_pkg;

  typedef enum logic [1:0] {StArb, StDrain, StFlush, StWaitCmplt} arb_state_e;

  typedef enum logic [1:0] {Size1B, Size2B, Size4B, Size8B} size_e;

  localparam int unsigned VadrW      = 48;
  localparam int unsigned DataW      = 64;
  localparam int unsigned RdctlW     = 32;
  localparam int unsigned RdctlIdLsb = 0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first eligible requester at or after the rr pointer.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    eligible,
  input  logic [IdxW-1:0] rr,
  output logic [N-1:0]    grant,
  output logic [IdxW-1:0] grant_idx,
  output logic            grant_any
);

  function automatic logic [IdxW-1:0] wrap_add(input logic [IdxW-1:0] base,
                                               input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= N) sum = sum - N;
    return IdxW'(sum);
  endfunction

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!grant_any && eligible[wrap_add(rr, k)]) begin
        grant_any = 1'b1;
        grant_idx = wrap_add(rr, k);
        grant[wrap_add(rr, k)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mc_port_arbiter.sv
// Shares one MC request/response port among NUM_REQ requesters: round-robin request
// stage, rdctl-tagged response routing, and serialised write flushes.
module mc_port_arbiter
  import mc_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ID_W      = 3,
  parameter int unsigned MAX_OUTST = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_ld,
  input  logic [2*NUM_REQ-1:0]  req_size,
  input  logic [48*NUM_REQ-1:0] req_vadr,
  input  logic [64*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_grant,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [63:0]           rsp_data,
  input  logic [NUM_REQ-1:0]    rsp_stall,
  input  logic [NUM_REQ-1:0]    flush_req,
  output logic [NUM_REQ-1:0]    flush_done,
  output logic                  mc_req_ld,
  output logic                  mc_req_st,
  output logic [1:0]            mc_req_size,
  output logic [47:0]           mc_req_vadr,
  output logic [63:0]           mc_req_wrd_rdctl,
  input  logic                  mc_rd_rq_stall,
  input  logic                  mc_wr_rq_stall,
  input  logic                  mc_rsp_push,
  input  logic [63:0]           mc_rsp_data,
  input  logic [31:0]           mc_rsp_rdctl,
  output logic                  mc_rsp_stall,
  output logic                  mc_req_flush,
  input  logic                  mc_rsp_flush_cmplt
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(MAX_OUTST) + 1;

  arb_state_e       state_q;
  logic             pend_valid_q, pend_ld_q;
  size_e            pend_size_q;
  logic [VadrW-1:0] pend_vadr_q;
  logic [DataW-1:0] pend_data_q;
  logic [IdxW-1:0]  pend_id_q, rr_q, fid_q;
  logic [CntW-1:0]  outst_q [NUM_REQ];
  logic             mc_rsp_stall_q, mc_req_flush_q, err_bad_id_q, err_underflow_q;

  logic               retire, can_grant, gnt_any, flush_any, rsp_bad, sel_ld;
  logic [NUM_REQ-1:0] eligible, gnt, pend_own, cnt_inc;
  logic [IdxW-1:0]    gnt_idx, flush_idx;
  logic [ID_W-1:0]    rsp_id;
  logic [1:0]         sel_size;
  logic [VadrW-1:0]   sel_vadr;
  logic [DataW-1:0]   sel_wdata;
  // Error flags are observed hierarchically only; upper rdctl bits carry no meaning here.
  logic               unused_sinks;

  assign mc_req_ld        = pend_valid_q & pend_ld_q & ~mc_rd_rq_stall;
  assign mc_req_st        = pend_valid_q & ~pend_ld_q & ~mc_wr_rq_stall;
  assign retire           = mc_req_ld | mc_req_st;
  assign mc_req_size      = pend_valid_q ? pend_size_q : Size1B;
  assign mc_req_vadr      = pend_valid_q ? pend_vadr_q : '0;
  assign mc_req_wrd_rdctl = pend_valid_q ? pend_data_q : '0;
  assign mc_rsp_stall     = mc_rsp_stall_q;
  assign mc_req_flush     = mc_req_flush_q;
  assign req_grant        = gnt;

  assign flush_any = |flush_req;
  assign can_grant = (state_q == StArb) & ~flush_any & (~pend_valid_q | retire);
  assign rsp_id    = mc_rsp_rdctl[RdctlIdLsb +: ID_W];
  assign rsp_bad   = 32'(rsp_id) >= NUM_REQ;
  assign rsp_data  = mc_rsp_push ? mc_rsp_data : '0;
  assign unused_sinks = err_bad_id_q ^ err_underflow_q ^ (^mc_rsp_rdctl);

  always_comb begin
    eligible   = '0;
    pend_own   = '0;
    cnt_inc    = '0;
    rsp_valid  = '0;
    flush_done = '0;
    flush_idx  = '0;
    sel_ld     = 1'b0;
    sel_size   = '0;
    sel_vadr   = '0;
    sel_wdata  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // A load already in the pending stage counts against its requester's budget.
      pend_own[i]   = pend_valid_q & pend_ld_q & (pend_id_q == IdxW'(i));
      cnt_inc[i]    = mc_req_ld & (pend_id_q == IdxW'(i));
      eligible[i]   = can_grant & req_valid[i] &
                      (~req_ld[i] | ((outst_q[i] + CntW'(pend_own[i])) < CntW'(MAX_OUTST)));
      rsp_valid[i]  = mc_rsp_push & (rsp_id == ID_W'(i));
      flush_done[i] = (state_q == StWaitCmplt) & mc_rsp_flush_cmplt & (fid_q == IdxW'(i));
      if (gnt[i]) begin
        sel_ld    = req_ld[i];
        sel_size  = req_size[2*i +: 2];
        sel_vadr  = req_vadr[48*i +: 48];
        sel_wdata = req_wdata[64*i +: 64];
      end
    end
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (flush_req[i]) flush_idx = IdxW'(i);
    end
  end

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr_arbiter (
    .eligible (eligible),
    .rr       (rr_q),
    .grant    (gnt),
    .grant_idx(gnt_idx),
    .grant_any(gnt_any)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StArb;
      fid_q          <= '0;
      mc_req_flush_q <= 1'b0;
    end else begin
      case (state_q)
        StArb: begin
          if (flush_any) begin
            state_q <= StDrain;
            fid_q   <= flush_idx;
          end
        end
        StDrain: begin
          if (!pend_valid_q) begin
            state_q        <= StFlush;
            mc_req_flush_q <= 1'b1;
          end
        end
        StFlush: begin
          state_q        <= StWaitCmplt;
          mc_req_flush_q <= 1'b0;
        end
        StWaitCmplt: begin
          if (mc_rsp_flush_cmplt) state_q <= StArb;
        end
        default: state_q <= StArb;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_valid_q    <= 1'b0;
      pend_ld_q       <= 1'b0;
      pend_size_q     <= Size1B;
      pend_vadr_q     <= '0;
      pend_data_q     <= '0;
      pend_id_q       <= '0;
      rr_q            <= '0;
      mc_rsp_stall_q  <= 1'b0;
      err_bad_id_q    <= 1'b0;
      err_underflow_q <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) outst_q[i] <= '0;
    end else begin
      if (gnt_any) begin
        pend_valid_q <= 1'b1;
        pend_ld_q    <= sel_ld;
        pend_size_q  <= size_e'(sel_size);
        pend_vadr_q  <= sel_vadr;
        pend_data_q  <= sel_ld ? (DataW'(gnt_idx) << RdctlIdLsb) : sel_wdata;
        pend_id_q    <= gnt_idx;
        rr_q         <= (gnt_idx == IdxW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (retire) begin
        pend_valid_q <= 1'b0;
      end
      mc_rsp_stall_q <= |rsp_stall;
      if (mc_rsp_push && rsp_bad) err_bad_id_q <= 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cnt_inc[i] && !rsp_valid[i]) begin
          if (outst_q[i] != '1) outst_q[i] <= outst_q[i] + 1'b1;
        end else if (rsp_valid[i] && !cnt_inc[i]) begin
          if (outst_q[i] == '0) err_underflow_q <= 1'b1;
          else outst_q[i] <= outst_q[i] - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mc_port_arbiter.sv
// Scoreboard bench for mc_port_arbiter: expected MC requests are queued at grant time
// and popped when the DUT strobes the MC port.
module tb_mc_port_arbiter;

  logic clock;
  logic reset;
  logic [3:0]   req_valid, req_ld, req_grant, rsp_valid, rsp_stall, flush_req, flush_done;
  logic [7:0]   req_size;
  logic [191:0] req_vadr;
  logic [255:0] req_wdata;
  logic [63:0]  rsp_data, mc_req_wrd_rdctl, mc_rsp_data;
  logic         mc_req_ld, mc_req_st, mc_rd_rq_stall, mc_wr_rq_stall, mc_rsp_push;
  logic [1:0]   mc_req_size;
  logic [47:0]  mc_req_vadr;
  logic [31:0]  mc_rsp_rdctl;
  logic         mc_rsp_stall, mc_req_flush, mc_rsp_flush_cmplt;

  typedef struct {
    logic        ld;
    logic [1:0]  size;
    logic [47:0] vadr;
    logic [63:0] data;
  } mc_exp_t;

  mc_exp_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int flush_pulses = 0;

  mc_port_arbiter #(
    .NUM_REQ(4),
    .ID_W(3),
    .MAX_OUTST(32)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ld            (req_ld),
    .req_size          (req_size),
    .req_vadr          (req_vadr),
    .req_wdata         (req_wdata),
    .req_grant         (req_grant),
    .rsp_valid         (rsp_valid),
    .rsp_data          (rsp_data),
    .rsp_stall         (rsp_stall),
    .flush_req         (flush_req),
    .flush_done        (flush_done),
    .mc_req_ld         (mc_req_ld),
    .mc_req_st         (mc_req_st),
    .mc_req_size       (mc_req_size),
    .mc_req_vadr       (mc_req_vadr),
    .mc_req_wrd_rdctl  (mc_req_wrd_rdctl),
    .mc_rd_rq_stall    (mc_rd_rq_stall),
    .mc_wr_rq_stall    (mc_wr_rq_stall),
    .mc_rsp_push       (mc_rsp_push),
    .mc_rsp_data       (mc_rsp_data),
    .mc_rsp_rdctl      (mc_rsp_rdctl),
    .mc_rsp_stall      (mc_rsp_stall),
    .mc_req_flush      (mc_req_flush),
    .mc_rsp_flush_cmplt(mc_rsp_flush_cmplt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input logic ld, input logic [1:0] size, input logic [47:0] vadr,
                          input logic [63:0] data);
    exp_q.push_back('{ld, size, vadr, data});
  endtask

  task automatic set_req(input int i, input logic ld, input logic [1:0] size,
                         input logic [47:0] vadr, input logic [63:0] wdata);
    req_valid[i]           = 1'b1;
    req_ld[i]              = ld;
    req_size[2*i +: 2]     = size;
    req_vadr[48*i +: 48]   = vadr;
    req_wdata[64*i +: 64]  = wdata;
  endtask

  task automatic do_reset();
    reset              = 1'b1;
    req_valid          = '0;
    req_ld             = '0;
    req_size           = '0;
    req_vadr           = '0;
    req_wdata          = '0;
    rsp_stall          = '0;
    flush_req          = '0;
    mc_rd_rq_stall     = 1'b0;
    mc_wr_rq_stall     = 1'b0;
    mc_rsp_push        = 1'b0;
    mc_rsp_data        = '0;
    mc_rsp_rdctl       = '0;
    mc_rsp_flush_cmplt = 1'b0;
    repeat (2) cyc();
    reset = 1'b0;
  endtask

  // Every MC strobe must match the oldest expected request.
  always @(negedge clock) begin
    if (!reset) begin
      if (mc_req_flush) flush_pulses++;
      if (mc_req_ld || mc_req_st) begin
        if (exp_q.size() == 0) begin
          check_eq("mc_req_unexpected", {62'd0, mc_req_ld, mc_req_st}, 64'd0);
        end else begin
          mc_exp_t e;
          e = exp_q.pop_front();
          check_eq("mc_req_kind", {62'd0, mc_req_ld, mc_req_st}, {62'd0, e.ld, ~e.ld});
          check_eq("mc_req_size", 64'(mc_req_size), 64'(e.size));
          check_eq("mc_req_vadr", 64'(mc_req_vadr), 64'(e.vadr));
          check_eq("mc_req_wrd_rdctl", mc_req_wrd_rdctl, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int flush_base;
    logic seen;

    // Reset state
    do_reset();
    @(negedge clock);
    check_eq("rst_grant", 64'(req_grant), 64'd0);
    check_eq("rst_strobes", {60'd0, mc_req_ld, mc_req_st, mc_req_flush, mc_rsp_stall}, 64'd0);
    check_eq("rst_vadr", 64'(mc_req_vadr), 64'd0);
    check_eq("rst_rr", 64'(dut.rr_q), 64'd0);
    check_eq("rst_outst0", 64'(dut.outst_q[0]), 64'd0);
    check_eq("rst_flush_done", 64'(flush_done), 64'd0);

    // All four requesters loading: strict rotation 0,1,2,3,0
    cyc();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 2'd3, 48'(32'h100 * (i + 1)), 64'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check_eq("s1_grant", 64'(req_grant), 64'd1 << (k % 4));
      if (k > 0) check_eq("s1_vadr_lag", 64'(mc_req_vadr), 64'(32'h100 * (((k - 1) % 4) + 1)));
      push_exp(1'b1, 2'd3, 48'(32'h100 * ((k % 4) + 1)), 64'(k % 4));
      cyc();
    end
    req_valid = '0;
    repeat (3) cyc();

    // Single load and its routed response
    do_reset();
    set_req(2, 1'b1, 2'd2, 48'h1000, 64'd0);
    @(negedge clock);
    check_eq("s2_grant", 64'(req_grant), 64'b0100);
    push_exp(1'b1, 2'd2, 48'h1000, 64'd2);
    cyc();
    req_valid = '0;
    @(negedge clock);
    check_eq("s2_mc_req_ld", 64'(mc_req_ld), 64'd1);
    cyc();
    @(negedge clock);
    check_eq("s2_outst_up", 64'(dut.outst_q[2]), 64'd1);
    cyc();
    mc_rsp_push  = 1'b1;
    mc_rsp_rdctl = 32'd2;
    mc_rsp_data  = 64'h55;
    @(negedge clock);
    check_eq("s2_rsp_valid", 64'(rsp_valid), 64'b0100);
    check_eq("s2_rsp_data", rsp_data, 64'h55);
    cyc();
    mc_rsp_push = 1'b0;
    @(negedge clock);
    check_eq("s2_outst_down", 64'(dut.outst_q[2]), 64'd0);

    // Store held by write stall; no grants while pending is stuck
    do_reset();
    mc_wr_rq_stall = 1'b1;
    set_req(1, 1'b0, 2'd3, 48'h2000, 64'hDEAD_BEEF);
    set_req(3, 1'b1, 2'd3, 48'h3000, 64'd0);
    @(negedge clock);
    check_eq("s3_grant_store", 64'(req_grant), 64'b0010);
    push_exp(1'b0, 2'd3, 48'h2000, 64'hDEAD_BEEF);
    cyc();
    req_valid[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check_eq("s3_st_held", 64'(mc_req_st), 64'd0);
      check_eq("s3_no_grant", 64'(req_grant), 64'd0);
      cyc();
    end
    mc_wr_rq_stall = 1'b0;
    @(negedge clock);
    check_eq("s3_st_release", 64'(mc_req_st), 64'd1);
    check_eq("s3_grant_next", 64'(req_grant), 64'b1000);
    push_exp(1'b1, 2'd3, 48'h3000, 64'd3);
    cyc();
    req_valid = '0;
    repeat (2) cyc();

    // Requester 0 hits the outstanding-load limit
    do_reset();
    set_req(0, 1'b1, 2'd3, 48'h4000, 64'd0);
    for (int k = 0; k < 32; k++) begin
      @(negedge clock);
      check_eq("s4_grant_r0", 64'(req_grant), 64'b0001);
      push_exp(1'b1, 2'd3, 48'h4000, 64'd0);
      cyc();
    end
    set_req(1, 1'b1, 2'd3, 48'h5000, 64'd0);
    @(negedge clock);
    check_eq("s4_skip_full", 64'(req_grant), 64'b0010);
    push_exp(1'b1, 2'd3, 48'h5000, 64'd1);
    cyc();
    req_valid[1] = 1'b0;
    set_req(0, 1'b0, 2'd3, 48'h4000, 64'h77);
    @(negedge clock);
    check_eq("s4_store_ok", 64'(req_grant), 64'b0001);
    push_exp(1'b0, 2'd3, 48'h4000, 64'h77);
    cyc();
    req_ld[0] = 1'b1;
    @(negedge clock);
    check_eq("s4_load_blocked", 64'(req_grant), 64'd0);
    check_eq("s4_outst_full", 64'(dut.outst_q[0]), 64'd32);
    cyc();
    mc_rsp_push  = 1'b1;
    mc_rsp_rdctl = 32'd0;
    mc_rsp_data  = 64'hAA;
    @(negedge clock);
    check_eq("s4_rsp_valid", 64'(rsp_valid), 64'b0001);
    check_eq("s4_blocked_in_rsp", 64'(req_grant), 64'd0);
    cyc();
    mc_rsp_push = 1'b0;
    @(negedge clock);
    check_eq("s4_reenabled", 64'(req_grant), 64'b0001);
    push_exp(1'b1, 2'd3, 48'h4000, 64'd0);
    cyc();
    req_valid = '0;
    repeat (2) cyc();

    // Flush while a store is pending
    do_reset();
    mc_wr_rq_stall = 1'b1;
    set_req(1, 1'b0, 2'd1, 48'h6000, 64'h1234);
    @(negedge clock);
    check_eq("s5_grant_store", 64'(req_grant), 64'b0010);
    push_exp(1'b0, 2'd1, 48'h6000, 64'h1234);
    flush_base = flush_pulses;
    cyc();
    req_valid    = '0;
    flush_req[1] = 1'b1;
    set_req(2, 1'b1, 2'd3, 48'h7000, 64'd0);
    @(negedge clock);
    check_eq("s5_no_grant_flushreq", 64'(req_grant), 64'd0);
    cyc();
    mc_wr_rq_stall = 1'b0;
    @(negedge clock);
    check_eq("s5_store_drains", 64'(mc_req_st), 64'd1);
    check_eq("s5_no_grant_drain", 64'(req_grant), 64'd0);
    cyc();
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clock);
      check_eq("s5_no_grant_wait", 64'(req_grant), 64'd0);
      if (mc_req_flush) seen = 1'b1;
      cyc();
    end
    check_eq("s5_flush_seen", 64'(seen), 64'd1);
    @(negedge clock);
    check_eq("s5_flush_one_cycle", 64'(mc_req_flush), 64'd0);
    check_eq("s5_done_early", 64'(flush_done), 64'd0);
    cyc();
    mc_rsp_flush_cmplt = 1'b1;
    flush_req          = '0;
    @(negedge clock);
    check_eq("s5_flush_done", 64'(flush_done), 64'b0010);
    check_eq("s5_no_grant_cmplt", 64'(req_grant), 64'd0);
    cyc();
    mc_rsp_flush_cmplt = 1'b0;
    @(negedge clock);
    check_eq("s5_grant_after", 64'(req_grant), 64'b0100);
    check_eq("s5_flush_count", 64'(flush_pulses - flush_base), 64'd1);
    push_exp(1'b1, 2'd3, 48'h7000, 64'd2);
    cyc();
    req_valid = '0;
    repeat (2) cyc();

    // Response stall register, bad id, counter underflow
    rsp_stall[3] = 1'b1;
    @(negedge clock);
    check_eq("s6_stall_not_yet", 64'(mc_rsp_stall), 64'd0);
    cyc();
    rsp_stall = '0;
    @(negedge clock);
    check_eq("s6_stall_reg", 64'(mc_rsp_stall), 64'd1);
    check_eq("s6_bad_id_clear", 64'(dut.err_bad_id_q), 64'd0);
    cyc();
    mc_rsp_push  = 1'b1;
    mc_rsp_rdctl = 32'd6;
    mc_rsp_data  = 64'h99;
    @(negedge clock);
    check_eq("s6_bad_id_dropped", 64'(rsp_valid), 64'd0);
    cyc();
    mc_rsp_push = 1'b0;
    @(negedge clock);
    check_eq("s6_err_bad_id", 64'(dut.err_bad_id_q), 64'd1);
    cyc();
    mc_rsp_push  = 1'b1;
    mc_rsp_rdctl = 32'd1;
    @(negedge clock);
    check_eq("s6_underflow_routed", 64'(rsp_valid), 64'b0010);
    cyc();
    mc_rsp_push = 1'b0;
    @(negedge clock);
    check_eq("s6_underflow_hold", 64'(dut.outst_q[1]), 64'd0);
    check_eq("s6_err_underflow", 64'(dut.err_underflow_q), 64'd1);

    check_eq("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
